// File: rtl/sensor_spi_reader.sv
// SPI master for the external 8-bit ADC. Each trigger converts the moisture channel,
// then the light channel, and publishes both bytes together with a one-cycle strobe.
module sensor_spi_reader #(
  parameter int         CLK_DIV       = 4,
  parameter int         SAMPLE_PERIOD = 1000,
  parameter logic [2:0] M_CHAN        = 3'd0,
  parameter logic [2:0] L_CHAN        = 3'd1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_req,
  input  logic       miso,
  output logic       sclk,
  output logic       cs_n,
  output logic       mosi,
  output logic [7:0] m_sense,
  output logic [7:0] l_sense,
  output logic       sample_valid,
  output logic       busy
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TMR_W = $clog2(SAMPLE_PERIOD);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(SAMPLE_PERIOD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [DIV_W-1:0] div_cnt;
  logic [4:0]       half_cnt;
  logic             chan_sel;
  logic [7:0]       shift_reg;
  logic [7:0]       m_data;
  logic [TMR_W-1:0] timer;
  logic             pending;

  logic       tick;
  logic       trigger;
  logic       div_last;
  logic       sample_edge;
  logic [7:0] cmd;

  assign tick     = (timer == TMR_MAX);
  assign trigger  = tick | sample_req;
  assign div_last = (div_cnt == DIV_MAX);
  assign cmd      = {5'b11000, (chan_sel ? L_CHAN : M_CHAN)};

  // half_cnt[4:1] is the SCLK period index, half_cnt[0] the high half; only the
  // reply bits (8..15) are captured, on the first clk of each high half.
  assign sample_edge = (state == S_SHIFT) && half_cnt[0] && half_cnt[4] && (div_cnt == '0);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (trigger) state_next = S_SETUP;
      S_SETUP: if (div_last) state_next = S_SHIFT;
      S_SHIFT: if (div_last && (half_cnt == 5'd31)) state_next = S_HOLD;
      S_HOLD:  if (div_last) state_next = chan_sel ? S_DONE : S_GAP;
      S_GAP:   if (div_last) state_next = S_SETUP;
      S_DONE:  state_next = (pending || trigger) ? S_SETUP : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sample timer and pending-trigger flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      timer   <= '0;
      pending <= 1'b0;
    end else begin
      timer <= tick ? '0 : timer + 1'b1;
      // A trigger seen in DONE restarts directly, so the flag is consumed there.
      if (state == S_DONE)                      pending <= 1'b0;
      else if ((state != S_IDLE) && trigger)    pending <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Phase counters and channel select
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt  <= '0;
      half_cnt <= '0;
      chan_sel <= 1'b0;
    end else begin
      if (state_next != state)  div_cnt <= '0;
      else if (state != S_IDLE) div_cnt <= div_last ? '0 : div_cnt + 1'b1;

      if (state != S_SHIFT)  half_cnt <= '0;
      else if (div_last)     half_cnt <= half_cnt + 1'b1;

      if ((state == S_IDLE) || (state == S_DONE)) chan_sel <= 1'b0;
      else if (state == S_GAP)                    chan_sel <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Data capture; both readings publish together on entry to DONE
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg <= '0;
      m_data    <= '0;
      m_sense   <= '0;
      l_sense   <= '0;
    end else begin
      if (sample_edge) shift_reg <= {shift_reg[6:0], miso};

      if ((state == S_HOLD) && div_last) begin
        if (!chan_sel) begin
          m_data <= shift_reg;
        end else begin
          m_sense <= m_data;
          l_sense <= shift_reg;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs decoded from registered state only
  // ---------------------------------------------------------------------------
  always_comb begin
    cs_n         = 1'b1;
    sclk         = 1'b0;
    mosi         = 1'b0;
    sample_valid = 1'b0;
    busy         = (state != S_IDLE);
    unique case (state)
      S_SETUP: begin
        cs_n = 1'b0;
        mosi = cmd[7];
      end
      S_SHIFT: begin
        cs_n = 1'b0;
        sclk = half_cnt[0];
        // mosi follows the period index, so it only moves as sclk falls.
        if (!half_cnt[4]) mosi = cmd[3'd7 - half_cnt[3:1]];
      end
      S_HOLD:  cs_n = 1'b0;
      S_DONE:  sample_valid = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sensor_spi_reader.sv
// Randomized bench for sensor_spi_reader: an ADC model answers the SPI traffic and a
// transaction-level timing model predicts every pin and reading cycle by cycle.
module tb_sensor_spi_reader;

  localparam int         D      = 4;
  localparam int         P      = 1000;
  localparam logic [2:0] M_CH   = 3'd0;
  localparam logic [2:0] L_CH   = 3'd1;
  localparam int         VALID_OFS = 69 * D;

  logic       clk = 1'b0;
  logic       reset;
  logic       sample_req;
  logic       miso = 1'b0;
  logic       sclk;
  logic       cs_n;
  logic       mosi;
  logic [7:0] m_sense;
  logic [7:0] l_sense;
  logic       sample_valid;
  logic       busy;

  sensor_spi_reader #(
    .CLK_DIV(D), .SAMPLE_PERIOD(P), .M_CHAN(M_CH), .L_CHAN(L_CH)
  ) dut (
    .clk(clk), .reset(reset), .sample_req(sample_req), .miso(miso),
    .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .m_sense(m_sense), .l_sense(l_sense),
    .sample_valid(sample_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model state, valid for the cycle currently in progress.
  int         cyc = 0;
  int         mt = 0;
  int         start = 0;
  int         model_pairs = 0;
  int         pairs_done = 0;
  int         fall_cyc = 0;
  int         rise_cnt = 0;
  bit         active = 0;
  bit         pending = 0;
  bit         armed = 0;
  bit         prev_reset = 1;
  bit         win_idx = 0;
  logic       prev_cs = 1'b1;
  logic       prev_sclk = 1'b0;
  logic [7:0] exp_m = 8'h00;
  logic [7:0] exp_l = 8'h00;
  logic [7:0] cmd_rx = 8'h00;
  logic [7:0] adc_val [8];

  initial begin
    for (int i = 0; i < 8; i++) adc_val[i] = 8'($urandom);
    adc_val[M_CH] = 8'hA5;
    adc_val[L_CH] = 8'h3C;
  end

  // Expected {cs_n, sclk, mosi, busy, sample_valid} at offset o from the first cs_n fall.
  function automatic logic [4:0] expected_pins(input bit act, input int o);
    logic [7:0] cmd_e;
    int         w, s, bidx;
    bit         in_win, e_sclk, e_mosi;
    if (!act) return 5'b10000;
    in_win = 1'b1;
    w      = 0;
    cmd_e  = {5'b11000, M_CH};
    if (o < 34 * D) begin
      w = o;
    end else if (o >= 35 * D && o < 69 * D) begin
      w = o - 35 * D;
      cmd_e = {5'b11000, L_CH};
    end else begin
      in_win = 1'b0;
    end
    if (!in_win) return {1'b1, 1'b0, 1'b0, 1'b1, (o == VALID_OFS)};
    e_sclk = 1'b0;
    e_mosi = 1'b0;
    if (w < D) begin
      e_mosi = cmd_e[7];
    end else if (w < 33 * D) begin
      s      = w - D;
      e_sclk = ((s / D) % 2) == 1;
      bidx   = s / (2 * D);
      if (bidx < 8) e_mosi = cmd_e[7 - bidx];
    end
    return {1'b0, e_sclk, e_mosi, 1'b1, 1'b0};
  endfunction

  always @(negedge clk) begin
    logic [7:0] bytev;
    bit         trig;
    if (armed) begin
      if (active && (cyc - start == VALID_OFS)) begin
        exp_m = adc_val[M_CH];
        exp_l = adc_val[L_CH];
      end
      check("pins", {cs_n, sclk, mosi, busy, sample_valid}, expected_pins(active, cyc - start));
      check("sense", {m_sense, l_sense}, {exp_m, exp_l});

      // Window bookkeeping from the observed bus
      if (!prev_cs && cs_n && !prev_reset) begin
        check("edges", rise_cnt, 16);
        check("cmd", cmd_rx, win_idx ? {5'b11000, L_CH} : {5'b11000, M_CH});
        win_idx = !win_idx;
      end
      if (prev_cs && !cs_n && !win_idx) fall_cyc = cyc;
      if (sample_valid) begin
        check("latency", cyc - fall_cyc, VALID_OFS);
        pairs_done++;
      end

      // ADC model: latch command on rising sclk, shift the reply out on falling sclk.
      if (cs_n) begin
        rise_cnt = 0;
      end else if (sclk && !prev_sclk) begin
        if (rise_cnt < 8) cmd_rx = {cmd_rx[6:0], mosi};
        rise_cnt++;
      end
      if (!cs_n && prev_sclk && !sclk && rise_cnt >= 8 && rise_cnt <= 15) begin
        bytev = adc_val[cmd_rx[2:0]];
        miso  = bytev[15 - rise_cnt];
      end else if (cs_n || (prev_sclk && !sclk)) begin
        miso = 1'($urandom);
      end
    end
    prev_cs    = cs_n;
    prev_sclk  = sclk;
    prev_reset = reset;

    // Trigger / pair scheduling for the next cycle
    if (reset) begin
      mt = 0; active = 0; pending = 0;
      exp_m = 8'h00; exp_l = 8'h00;
      win_idx = 0; rise_cnt = 0; armed = 1;
    end else if (armed) begin
      trig = (mt == P - 1) || sample_req;
      mt   = (mt == P - 1) ? 0 : mt + 1;
      if (!active) begin
        if (trig) begin active = 1; start = cyc + 1; end
      end else if (cyc - start == VALID_OFS) begin
        model_pairs++;
        for (int i = 0; i < 8; i++) adc_val[i] = 8'($urandom);
        if (model_pairs == 1) begin adc_val[M_CH] = 8'h00; adc_val[L_CH] = 8'hFF; end
        if (model_pairs == 2) begin adc_val[M_CH] = 8'hFF; adc_val[L_CH] = 8'h00; end
        if (pending || trig) begin start = cyc + 1; pending = 0; end
        else active = 0;
      end else begin
        pending = pending | trig;
      end
    end
    cyc++;
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_pairs(input int target, input int budget);
    int n = 0;
    while (pairs_done < target && n < budget) begin cycles(1); n++; end
    if (pairs_done < target) check("wait_tmo", pairs_done, target);
  endtask

  task automatic wait_idle_at(input int mt_target, input int budget);
    int n = 0;
    while ((active || (mt_target >= 0 && mt != mt_target)) && n < budget) begin
      cycles(1);
      n++;
    end
    if (active) check("idle_tmo", 32'(active), 32'd0);
  endtask

  task automatic pulse_req(input int len);
    sample_req = 1'b1;
    cycles(len);
    sample_req = 1'b0;
  endtask

  initial begin
    int p0;
    int n;
    reset      = 1'b1;
    sample_req = 1'b0;
    cycles(3);
    check("rst_out", {cs_n, sclk, mosi, m_sense, l_sense, sample_valid, busy},
          {1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0});
    reset = 1'b0;

    // First pair comes from the timer tick: A5 / 3C.
    wait_pairs(1, 1400);
    cycles(1);
    check("first_m", m_sense, 8'hA5);
    check("first_l", l_sense, 8'h3C);

    // Requested pairs carrying the 00/FF and FF/00 extremes.
    wait_idle_at(-1, 400);
    pulse_req(1);
    wait_pairs(2, 400);
    wait_idle_at(-1, 400);
    pulse_req(1);
    wait_pairs(3, 400);
    cycles(1);
    check("ext_m", m_sense, 8'hFF);
    check("ext_l", l_sense, 8'h00);

    // Held request plus a timer tick merge into one extra pair.
    wait_idle_at(P - 100, 3000);
    p0 = pairs_done;
    sample_req = 1'b1;
    cycles(200);
    sample_req = 1'b0;
    cycles(700);
    check("extra_pair", pairs_done - p0, 2);

    // Reset during light channel SHIFT bit 10 aborts the pair.
    wait_idle_at(-1, 400);
    pulse_req(1);
    n = 0;
    while (!(active && (cyc - start == 57 * D + 1)) && n < 400) begin cycles(1); n++; end
    p0 = pairs_done;
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    check("abort_pins", {cs_n, sclk, m_sense, l_sense, sample_valid},
          {1'b1, 1'b0, 8'h00, 8'h00, 1'b0});
    cycles(300);
    check("abort_no_valid", pairs_done - p0, 0);
    pulse_req(1);
    wait_pairs(p0 + 1, 400);

    // Random request traffic over at least 20 more pairs.
    p0 = pairs_done;
    for (int k = 0; k < 200 && pairs_done < p0 + 20; k++) begin
      cycles($urandom_range(0, 350));
      pulse_req($urandom_range(1, 4));
    end
    check("random_pairs", 32'(pairs_done >= p0 + 20), 32'd1);
    wait_idle_at(-1, 700);
    cycles(5);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
